// File: rtl/bcd_pkg.sv
// Purpose: shared types and constants for the BCD <-> binary conversion blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, digit count/limits, minimum binary result width, digit check helper.
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam int         NUM_DIGITS   = 4;
  localparam logic [3:0] MAX_DIGIT    = 4'd9;
  // 9999 needs 14 bits; narrower result widths cannot hold the full range.
  localparam int         MIN_BIN_BITS = 14;

  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > MAX_DIGIT);
  endfunction

endpackage

// File: rtl/mul10_add.sv
// Purpose: one step of decimal accumulation, result = acc*10 + digit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: acc [BITS] running value, digit [4] next BCD digit, result [BITS] updated value.
module mul10_add
  import bcd_pkg::*;
#(
  parameter int BITS = MIN_BIN_BITS
) (
  input  logic [BITS-1:0] acc,
  input  logic [3:0]      digit,
  output logic [BITS-1:0] result
);

  // x*10 = x*8 + x*2; callers keep acc small enough that BITS never wraps
  // for valid BCD input.
  always_comb begin
    result = (acc << 3) + (acc << 1) + BITS'(digit);
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Purpose: sequential 4-digit BCD to unsigned binary converter (0..9999) with digit validation.
// Latency: done pulses 4 clocks after the edge that accepts start; one conversion per 5 clocks max.
// Backpressure: start is only sampled while idle; requests during busy are dropped, not queued.
// Ports: clk, rst_n (sync, active-low), start, digit3..digit0 (thousands..units),
//        busy, done (1-cycle pulse), binary [BITS], error (a captured digit was > 9).
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int BITS = MIN_BIN_BITS  // must be >= MIN_BIN_BITS; upper bits are zero-filled
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      digit3,
  input  logic [3:0]      digit2,
  input  logic [3:0]      digit1,
  input  logic [3:0]      digit0,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] binary,
  output logic            error
);

  localparam int               CNT_W    = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BITS-1:0]                acc_q, acc_d;
  // Captured digits stored in processing order: index 0 is the thousands digit.
  logic [NUM_DIGITS-1:0][3:0]     digs_q, digs_d;
  logic                           invalid_q, invalid_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [BITS-1:0]                binary_q, binary_d;
  logic                           error_q, error_d;

  logic [BITS-1:0]                mac_result;
  logic                           last_step;

  mul10_add #(
    .BITS (BITS)
  ) u_mul10_add (
    .acc    (acc_q),
    .digit  (digs_q[cnt_q]),
    .result (mac_result)
  );

  assign last_step = (cnt_q == LAST_CNT);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      digs_q    <= '0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      binary_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      digs_q    <= digs_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      binary_q  <= binary_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = CONV;
      CONV:    if (last_step) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    digs_d    = digs_q;
    invalid_d = invalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    binary_d  = binary_q;
    error_d   = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          digs_d    = {digit0, digit1, digit2, digit3};
          invalid_d = digit_invalid(digit3) | digit_invalid(digit2) |
                      digit_invalid(digit1) | digit_invalid(digit0);
          acc_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      CONV: begin
        acc_d = mac_result;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          // An invalid entry still runs all steps so timing is data-independent;
          // only the published result is suppressed.
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          binary_d = invalid_q ? '0 : mac_result;
          error_d  = invalid_q;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = binary_q;
  assign error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  localparam int BITS = 14;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [3:0]      digit3, digit2, digit1, digit0;
  logic            busy, done, error;
  logic [BITS-1:0] binary;

  int tests_run;
  int tests_failed;

  bcd_to_binary #(.BITS(BITS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .digit3 (digit3),
    .digit2 (digit2),
    .digit1 (digit1),
    .digit0 (digit0),
    .busy   (busy),
    .done   (done),
    .binary (binary),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d3, d2, d1, d0;
    int         exp_bin;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    digit3 = a; digit2 = b; digit1 = c; digit0 = d;
  endtask

  // One start pulse; waits (bounded) for done. Inputs change at negedge, outputs sampled at negedge.
  task automatic conv(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d,
                      output int bin, output int err, output int lat,
                      output int busy_cnt, output int busy_at_done, output int got_done);
    @(negedge clk);
    set_digits(a, b, c, d);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_cnt = 0; got_done = 0; busy_at_done = 0; bin = 0; err = 0;
    for (int k = 1; k <= 10; k++) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      @(negedge clk);
      lat = k;
      if (done) begin
        got_done     = 1;
        busy_at_done = int'(busy);
        bin          = int'(binary);
        err          = int'(error);
        break;
      end
    end
  endtask

  int bin, err, lat, bcnt, bdone, got;
  int done_cnt;
  int got_ref;

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);

    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1234, 1'b0};
    vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 9999, 1'b0};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 0,    1'b0};
    vecs[3] = '{4'd1, 4'd2, 4'hA, 4'd4, 0,    1'b1};
    vecs[4] = '{4'd0, 4'd0, 4'd4, 4'd2, 42,   1'b0};
    vecs[5] = '{4'd5, 4'd0, 4'd0, 4'd5, 5005, 1'b0};
    vecs[6] = '{4'd0, 4'd0, 4'd0, 4'd9, 9,    1'b0};
    vecs[7] = '{4'hF, 4'd0, 4'd0, 4'd0, 0,    1'b1};
    vecs[8] = '{4'd8, 4'd0, 4'd7, 4'd6, 8076, 1'b0};
    vecs[9] = '{4'd1, 4'd0, 4'd0, 4'd0, 1000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_binary", int'(binary), 0);
    check("reset_error", int'(error), 0);
    rst_n = 1'b1;

    // Table-driven conversions
    foreach (vecs[i]) begin
      conv(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0, bin, err, lat, bcnt, bdone, got);
      check($sformatf("v%0d_done_seen", i), got, 1);
      check($sformatf("v%0d_latency", i), lat, 4);
      check($sformatf("v%0d_busy_cycles", i), bcnt, 4);
      check($sformatf("v%0d_busy_at_done", i), bdone, 0);
      check($sformatf("v%0d_binary", i), bin, vecs[i].exp_bin);
      check($sformatf("v%0d_error", i), err, int'(vecs[i].exp_err));
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), int'(done), 0);
      check($sformatf("v%0d_binary_hold", i), int'(binary), vecs[i].exp_bin);
      check($sformatf("v%0d_error_hold", i), int'(error), int'(vecs[i].exp_err));
    end

    // Input changes and start re-pulse while busy are ignored
    @(negedge clk);
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    start = 1'b1;
    @(posedge clk);                 // accepting edge
    @(negedge clk);
    start = 1'b0;
    set_digits(4'd1, 4'd1, 4'd1, 4'd1);
    done_cnt = 0;
    bin = -1;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        bin = int'(binary);
      end
    end
    check("busy_ignore_done_count", done_cnt, 1);
    check("busy_ignore_binary", bin, 5678);

    // Reset during second CONV cycle aborts and clears outputs
    @(negedge clk);
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    start = 1'b1;
    @(posedge clk);                 // accept
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);                 // first CONV step
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_binary", int'(binary), 0);
    check("abort_error", int'(error), 0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    // Back-to-back sweep of 0..9999 with start held high
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    start = 1'b1;
    for (int n = 0; n <= 9999; n++) begin
      @(posedge clk);               // accepting edge
      @(negedge clk);
      set_digits(4'hF, 4'hF, 4'hF, 4'hF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (n < 9999)
        set_digits(4'((n + 1) / 1000), 4'(((n + 1) / 100) % 10),
                   4'(((n + 1) / 10) % 10), 4'((n + 1) % 10));
      else
        start = 1'b0;
      @(posedge clk);               // done edge
      @(negedge clk);
      got_ref = (1 << 15) | n;      // {done=1, error=0, binary=n}
      check($sformatf("sweep_%0d", n),
            (int'(done) << 15) | (int'(error) << 14) | int'(binary), got_ref);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
